// File: rtl/dmem_io_resp.sv
// Data-side responder for the MIPS core load/store port.
// Holds the data RAM, an LED register, a synchronised switch input and a
// compare-match timer that raises one interrupt line. Loads return data
// combinationally in the request cycle; stores take effect on the rising edge.
module dmem_io_resp #(
  parameter int          RAM_AW        = 10,
  parameter logic [31:0] IO_BASE       = 32'h0000_8000,
  parameter int          TIMER_IRQ_BIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic [5:0]  intr,
  output logic        bus_err
);

  localparam logic [29:0] IO_WBASE = IO_BASE[31:2];

  // IO register word offsets inside the window
  localparam logic [2:0] OFF_LED   = 3'd0;
  localparam logic [2:0] OFF_SW    = 3'd1;
  localparam logic [2:0] OFF_TCMP  = 3'd2;
  localparam logic [2:0] OFF_TCNT  = 3'd3;
  localparam logic [2:0] OFF_TCTRL = 3'd4;

  logic [31:0] r_ram [2**RAM_AW];
  logic [15:0] r_led;
  logic [15:0] r_sw1;
  logic [15:0] r_sw2;
  logic [31:0] r_tcmp;
  logic [31:0] r_tcnt;
  logic        r_en;
  logic        r_pend;
  logic        r_busErr;

  logic              w_ramHit;
  logic [29:0]       w_ioOff;
  logic              w_ioHit;
  logic [2:0]        w_ioSel;
  logic [RAM_AW-1:0] w_ramIdx;
  logic              w_wr;
  logic              w_wrLed;
  logic              w_wrTcmp;
  logic              w_wrTcnt;
  logic              w_wrTctrl;
  logic              w_unmapped;
  logic              w_cntRun;
  logic              w_match;
  logic [31:0]       w_rd;
  logic [5:0]        w_intr;
  logic              w_unused;

  // Byte lane bits are irrelevant for word-only accesses
  assign w_unused = ^memAddr[1:0];

  assign w_ramHit = (memAddr[31:RAM_AW+2] == '0);
  assign w_ioOff  = memAddr[31:2] - IO_WBASE;
  assign w_ioHit  = !w_ramHit && (w_ioOff < 30'd5);
  assign w_ioSel  = w_ioOff[2:0];
  assign w_ramIdx = memAddr[RAM_AW+1:2];

  // Decode store strobes, the unmapped condition and the timer run/match state
  always_comb begin
    w_wr       = memCe && memWr;
    w_wrLed    = w_wr && w_ioHit && (w_ioSel == OFF_LED);
    w_wrTcmp   = w_wr && w_ioHit && (w_ioSel == OFF_TCMP);
    w_wrTcnt   = w_wr && w_ioHit && (w_ioSel == OFF_TCNT);
    w_wrTctrl  = w_wr && w_ioHit && (w_ioSel == OFF_TCTRL);
    w_unmapped = memCe && !w_ramHit && !w_ioHit;
    // A disabling TCTRL write freezes the counter at this very edge
    w_cntRun   = r_en && !(w_wrTctrl && !wtData[0]);
    w_match    = w_cntRun && (r_tcnt == r_tcmp);
  end

  // Combinational read mux; stores also see the old word (read-before-write)
  always_comb begin
    w_rd = '0;
    if (memCe) begin
      if (w_ramHit) begin
        w_rd = r_ram[w_ramIdx];
      end else if (w_ioHit) begin
        case (w_ioSel)
          OFF_LED:   w_rd = {16'h0000, r_led};
          OFF_SW:    w_rd = {16'h0000, r_sw2};
          OFF_TCMP:  w_rd = r_tcmp;
          OFF_TCNT:  w_rd = r_tcnt;
          OFF_TCTRL: w_rd = {30'd0, r_pend, r_en};
          default:   w_rd = '0;
        endcase
      end
    end
  end

  // Place the pending flag on its interrupt line, all others tied low
  always_comb begin
    w_intr                = '0;
    w_intr[TIMER_IRQ_BIT] = r_pend;
  end

  // Data RAM write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (rst && w_wr && w_ramHit) begin
      r_ram[w_ramIdx] <= wtData;
    end
  end

  // IO registers, switch synchroniser, timer and sticky bus error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led    <= '0;
      r_sw1    <= '0;
      r_sw2    <= '0;
      r_tcmp   <= 32'hFFFF_FFFF;
      r_tcnt   <= '0;
      r_en     <= 1'b0;
      r_pend   <= 1'b0;
      r_busErr <= 1'b0;
    end else begin
      r_sw1 <= sw;
      r_sw2 <= r_sw1;
      if (w_wrLed) begin
        r_led <= wtData[15:0];
      end
      if (w_wrTcmp) begin
        r_tcmp <= wtData;
      end
      if (w_wrTcnt) begin
        r_tcnt <= wtData;
      end else if (w_match) begin
        r_tcnt <= '0;
      end else if (w_cntRun) begin
        r_tcnt <= r_tcnt + 32'd1;
      end
      if (w_wrTctrl) begin
        r_en <= wtData[0];
      end
      if (w_match) begin
        r_pend <= 1'b1;
      end else if (w_wrTctrl && wtData[1]) begin
        r_pend <= 1'b0;
      end
      if (w_unmapped) begin
        r_busErr <= 1'b1;
      end
    end
  end

  assign rdData  = w_rd;
  assign led     = r_led;
  assign intr    = w_intr;
  assign bus_err = r_busErr;

endmodule

// File: tb/tb_dmem_io_resp.sv
// Directed bench for dmem_io_resp: a vector table for RAM/LED/SW/unmapped
// accesses plus hand-written timer, collision and asynchronous reset sequences.
module tb_dmem_io_resp;

  localparam logic [31:0] A_LED   = 32'h0000_8000;
  localparam logic [31:0] A_SW    = 32'h0000_8004;
  localparam logic [31:0] A_TCMP  = 32'h0000_8008;
  localparam logic [31:0] A_TCNT  = 32'h0000_800C;
  localparam logic [31:0] A_TCTRL = 32'h0000_8010;

  logic        clk;
  logic        rst;
  logic        memCe;
  logic        memWr;
  logic [31:0] memAddr;
  logic [31:0] wtData;
  logic [31:0] rdData;
  logic [15:0] sw;
  logic [15:0] led;
  logic [5:0]  intr;
  logic        bus_err;

  int nChecks;
  int nFail;

  typedef struct {
    string       name;
    logic        ce;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        chkRd;
    logic [31:0] expRd;
    logic [15:0] expLed;
    logic        expErr;
  } vec_t;

  vec_t vecs[23];

  dmem_io_resp #(
    .RAM_AW(10),
    .IO_BASE(32'h0000_8000),
    .TIMER_IRQ_BIT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .memCe(memCe),
    .memWr(memWr),
    .memAddr(memAddr),
    .wtData(wtData),
    .rdData(rdData),
    .sw(sw),
    .led(led),
    .intr(intr),
    .bus_err(bus_err)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ce, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data);
    memCe   = ce;
    memWr   = wr;
    memAddr = addr;
    wtData  = data;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkLoad(input string name, input logic [31:0] addr,
                           input logic [31:0] exp);
    applyStimulus(1'b1, 1'b0, addr, 32'h0);
    checkOutput(name, rdData, exp);
  endtask

  task automatic setVec(input int i, input string name, input logic ce,
                        input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic chkRd,
                        input logic [31:0] expRd, input logic [15:0] expLed,
                        input logic expErr);
    vecs[i].name   = name;
    vecs[i].ce     = ce;
    vecs[i].wr     = wr;
    vecs[i].addr   = addr;
    vecs[i].data   = data;
    vecs[i].chkRd  = chkRd;
    vecs[i].expRd  = expRd;
    vecs[i].expLed = expLed;
    vecs[i].expErr = expErr;
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    rst     = 1'b0;
    sw      = 16'h0000;
    idle();

    // Expected values hold for the cycle in which each vector is driven,
    // i.e. the state before that vector's own edge.
    setVec(0,  "st_ram10",    1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0,          16'h0000, 0);
    setVec(1,  "ld_ram10",    1, 0, 32'h0000_0010, 32'h0,         1, 32'hDEAD_BEEF,  16'h0000, 0);
    setVec(2,  "ld_ram13",    1, 0, 32'h0000_0013, 32'h0,         1, 32'hDEAD_BEEF,  16'h0000, 0);
    setVec(3,  "rdw_ram10",   1, 1, 32'h0000_0010, 32'h1111_1111, 1, 32'hDEAD_BEEF,  16'h0000, 0);
    setVec(4,  "ld_ram10b",   1, 0, 32'h0000_0010, 32'h0,         1, 32'h1111_1111,  16'h0000, 0);
    setVec(5,  "ce0_rd",      0, 0, 32'h0000_0010, 32'h0,         1, 32'h0,          16'h0000, 0);
    setVec(6,  "st_ramtop",   1, 1, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 32'h0,          16'h0000, 0);
    setVec(7,  "ld_ramtop",   1, 0, 32'h0000_0FFC, 32'h0,         1, 32'hCAFE_F00D,  16'h0000, 0);
    setVec(8,  "st_led",      1, 1, A_LED,         32'h1234_ABCD, 1, 32'h0,          16'h0000, 0);
    setVec(9,  "ld_led",      1, 0, A_LED,         32'h0,         1, 32'h0000_ABCD,  16'hABCD, 0);
    setVec(10, "ce0_st_led",  0, 1, A_LED,         32'h0,         1, 32'h0,          16'hABCD, 0);
    setVec(11, "st_sw_ro",    1, 1, A_SW,          32'hFFFF_FFFF, 1, 32'h0000_00F0,  16'hABCD, 0);
    setVec(12, "ld_sw",       1, 0, A_SW,          32'h0,         1, 32'h0000_00F0,  16'hABCD, 0);
    setVec(13, "ld_tcmp_rst", 1, 0, A_TCMP,        32'h0,         1, 32'hFFFF_FFFF,  16'hABCD, 0);
    setVec(14, "ld_tcnt_rst", 1, 0, A_TCNT,        32'h0,         1, 32'h0,          16'hABCD, 0);
    setVec(15, "ld_tctrl_rst",1, 0, A_TCTRL,       32'h0,         1, 32'h0,          16'hABCD, 0);
    setVec(16, "ld_led_keep", 1, 0, A_LED,         32'h0,         1, 32'h0000_ABCD,  16'hABCD, 0);
    setVec(17, "ld_unmapped", 1, 0, 32'h0001_0000, 32'h0,         1, 32'h0,          16'hABCD, 0);
    setVec(18, "err_sticky",  1, 0, 32'h0000_0010, 32'h0,         1, 32'h1111_1111,  16'hABCD, 1);
    setVec(19, "st_io_hole",  1, 1, 32'h0000_8020, 32'hFFFF_FFFF, 1, 32'h0,          16'hABCD, 1);
    setVec(20, "st_ram_end",  1, 1, 32'h0000_1000, 32'hFFFF_FFFF, 1, 32'h0,          16'hABCD, 1);
    setVec(21, "ld_led_err",  1, 0, A_LED,         32'h0,         1, 32'h0000_ABCD,  16'hABCD, 1);
    setVec(22, "ld_ram_end",  1, 0, 32'h0000_1000, 32'h0,         1, 32'h0,          16'hABCD, 1);

    // Reset values while reset is held
    #2;
    checkOutput("rst_led", {16'h0, led}, 32'h0);
    checkOutput("rst_intr", {26'h0, intr}, 32'h0);
    checkOutput("rst_buserr", {31'h0, bus_err}, 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Switch synchroniser: new value appears two edges after the change
    sw = 16'h00F0;
    checkLoad("sw_edge0", A_SW, 32'h0);
    tick();
    checkLoad("sw_edge1", A_SW, 32'h0);
    tick();
    checkLoad("sw_edge2", A_SW, 32'h0000_00F0);
    tick();

    // Table-driven RAM / LED / SW / unmapped vectors
    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].ce, vecs[i].wr, vecs[i].addr, vecs[i].data);
      if (vecs[i].chkRd) begin
        checkOutput({vecs[i].name, "_rd"}, rdData, vecs[i].expRd);
      end
      checkOutput({vecs[i].name, "_led"}, {16'h0, led}, {16'h0, vecs[i].expLed});
      checkOutput({vecs[i].name, "_err"}, {31'h0, bus_err}, {31'h0, vecs[i].expErr});
      tick();
    end

    // Timer: TCMP=4, enable, match cycle TCNT=4, pending 5 edges after enable
    applyStimulus(1, 1, A_TCMP, 32'd4);
    tick();
    applyStimulus(1, 1, A_TCTRL, 32'd1);
    tick();
    idle();
    checkOutput("tmr_intr_e0", {26'h0, intr}, 32'h0);
    tick();
    tick();
    tick();
    tick();
    checkLoad("tmr_tcnt_match", A_TCNT, 32'd4);
    checkOutput("tmr_intr_e4", {26'h0, intr}, 32'h0);
    tick();
    checkOutput("tmr_intr_rise", {26'h0, intr}, 32'h4);
    checkLoad("tmr_tcnt_wrap0", A_TCNT, 32'd0);
    tick();
    // TCNT=1 here: clear pending, keep enable
    applyStimulus(1, 1, A_TCTRL, 32'd3);
    tick();
    checkOutput("tmr_w1c", {26'h0, intr}, 32'h0);
    checkLoad("tmr_tctrl_en", A_TCTRL, 32'd1);
    tick();
    idle();
    tick();
    checkOutput("tmr_intr_e9", {26'h0, intr}, 32'h0);
    tick();
    checkOutput("tmr_intr_rise2", {26'h0, intr}, 32'h4);
    checkLoad("tmr_tctrl_pend", A_TCTRL, 32'd3);

    // Collision: W1C in a match cycle, set wins
    applyStimulus(1, 1, A_TCTRL, 32'd3);
    tick();
    checkOutput("col_clear_first", {26'h0, intr}, 32'h0);
    idle();
    tick();
    tick();
    tick();
    checkLoad("col_tcnt4", A_TCNT, 32'd4);
    applyStimulus(1, 1, A_TCTRL, 32'd3);
    tick();
    checkOutput("col_w1c_setwins", {26'h0, intr}, 32'h4);
    checkLoad("col_w1c_tcnt0", A_TCNT, 32'd0);

    // Collision: TCNT write in a match cycle wins over auto-clear
    applyStimulus(1, 1, A_TCTRL, 32'd3);
    tick();
    idle();
    tick();
    tick();
    tick();
    checkOutput("col2_pend0", {26'h0, intr}, 32'h0);
    applyStimulus(1, 1, A_TCNT, 32'd7);
    tick();
    checkLoad("col_tcnt_wr7", A_TCNT, 32'd7);
    checkOutput("col_tcnt_intr", {26'h0, intr}, 32'h4);
    tick();

    // Disable: TCNT=8 holds from the disabling edge on, pending untouched
    applyStimulus(1, 1, A_TCTRL, 32'd0);
    tick();
    checkLoad("dis_tcnt_hold", A_TCNT, 32'd8);
    checkOutput("dis_pend_kept", {26'h0, intr}, 32'h4);
    tick();
    checkLoad("dis_tcnt_hold2", A_TCNT, 32'd8);
    tick();

    // Wrap 0xFFFFFFFF -> 0 without a match
    applyStimulus(1, 1, A_TCMP, 32'h10);
    tick();
    applyStimulus(1, 1, A_TCNT, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1, 1, A_TCTRL, 32'd3);
    tick();
    checkLoad("wrap_hold", A_TCNT, 32'hFFFF_FFFF);
    tick();
    checkLoad("wrap_zero", A_TCNT, 32'd0);
    checkOutput("wrap_noflag", {26'h0, intr}, 32'h0);
    tick();

    // Async reset mid-run with led, pending and bus_err all set
    applyStimulus(1, 1, A_TCNT, 32'h10);
    tick();
    idle();
    tick();
    applyStimulus(1, 1, A_LED, 32'h0000_FFFF);
    tick();
    checkLoad("pre_rst_led", A_LED, 32'h0000_FFFF);
    checkOutput("pre_rst_intr", {26'h0, intr}, 32'h4);
    checkOutput("pre_rst_err", {31'h0, bus_err}, 32'h1);
    rst = 1'b0;
    #1;
    checkOutput("arst_led", {16'h0, led}, 32'h0);
    checkOutput("arst_intr", {26'h0, intr}, 32'h0);
    checkOutput("arst_err", {31'h0, bus_err}, 32'h0);
    checkOutput("arst_rd", rdData, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checkLoad("post_rst_tcnt", A_TCNT, 32'h0);
    tick();
    checkLoad("post_rst_tcnt2", A_TCNT, 32'h0);
    checkLoad("post_rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
    checkLoad("post_rst_tctrl", A_TCTRL, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
    $finish;
  end

endmodule
